// File: rtl/sfifo_pkg.sv
// sfifo_pkg
// Shared definitions for the parametrised single-clock FIFO:
//   clog2          - constant function used to size pointers and the fill count
//   FWFT_*         - encodings of the first-word-fall-through prefetch states
//   fwft_state_t   - enum type built on those encodings
package sfifo_pkg;

    localparam logic [1:0] FWFT_IDLE  = 2'd0;
    localparam logic [1:0] FWFT_FETCH = 2'd1;
    localparam logic [1:0] FWFT_VALID = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = FWFT_IDLE,
        ST_FETCH = FWFT_FETCH,
        ST_VALID = FWFT_VALID
    } fwft_state_t;

    // Ceiling log2, usable in parameter expressions (clog2(16) == 4).
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/sfifo_ram.sv
// sfifo_ram
// Simple dual-port memory for the FIFO: one synchronous write port and one
// registered read port with read enable. The array has no reset so that the
// tools can map it onto block RAM or distributed RAM.
// Ports:
//   clk    in   clock, rising edge
//   we     in   write enable
//   waddr  in   write address (AW bits)
//   wdata  in   write data (DATA_W bits)
//   re     in   read enable; rdata updates only when set
//   raddr  in   read address (AW bits)
//   rdata  out  registered read data (DATA_W bits)
module sfifo_ram
    import sfifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter int AW     = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Write port: the FIFO never writes and reads the same address in one
    // cycle, so no read-during-write behaviour needs to be defined.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered output, held while re is low.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/sfifo_param.sv
// sfifo_param
// Parametrised single-clock FIFO with either first-word-fall-through (FWFT=1)
// or standard one-cycle-latency read (FWFT=0). It provides programmable
// almost-full and almost-empty thresholds, a fill count, and one-cycle
// overflow and underflow pulses.
// Ports:
//   clk           in   clock, all logic on the rising edge
//   rst_n         in   asynchronous active-low reset, released through a 2-flop synchroniser
//   din/wr_en     in   write data / write request
//   full          out  no space; writes are ignored
//   almost_full   out  count >= AF_LVL
//   dout          out  read data
//   rd_en         in   read request (FWFT: pop the word shown on dout)
//   empty         out  nothing readable (FWFT: dout invalid)
//   almost_empty  out  count <= AE_LVL
//   count         out  words held, including the FWFT output and skid registers
//   overflow      out  one-cycle pulse after wr_en while full
//   underflow     out  one-cycle pulse after rd_en while empty
module sfifo_param
    import sfifo_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 512,
    parameter bit FWFT   = 1'b1,
    parameter int AF_LVL = 480,
    parameter int AE_LVL = 32,
    localparam int AW    = clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] din,
    input  logic              wr_en,
    output logic              full,
    output logic              almost_full,
    output logic [DATA_W-1:0] dout,
    input  logic              rd_en,
    output logic              empty,
    output logic              almost_empty,
    output logic [AW:0]       count,
    output logic              overflow,
    output logic              underflow
);

    logic [1:0]        rst_sync;
    logic              rst_int_n;
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       count_next;
    logic [AW:0]       ram_words;
    logic [AW:0]       ram_words_next;
    logic              wr_acc;
    logic              rd_acc;
    logic              ram_re;
    logic [DATA_W-1:0] ram_q;
    logic [DATA_W-1:0] skid_q;
    logic              skid_vld;
    logic              q_vld;
    logic              rd_pend;
    logic              out_vld;
    logic              fetch;
    logic [1:0]        held_after;
    fwft_state_t       state;
    fwft_state_t       state_next;

    // Reset asserts immediately but releases only after two clean clock
    // edges, so no register leaves reset on a marginal edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rst_sync <= 2'b00;
        end else begin
            rst_sync <= {rst_sync[0], 1'b1};
        end
    end

    assign rst_int_n = rst_sync[1];

    // In FWFT mode, "empty" means the output register is invalid. A pop is
    // therefore always a pop of the word currently on dout.
    assign wr_acc         = wr_en && !full;
    assign rd_acc         = rd_en && !empty;
    assign ram_re         = FWFT ? fetch : rd_acc;
    assign count_next     = count + (AW+1)'(wr_acc) - (AW+1)'(rd_acc);
    assign ram_words_next = ram_words + (AW+1)'(wr_acc) - (AW+1)'(ram_re);

    sfifo_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (din),
        .re    (ram_re),
        .raddr (rd_ptr),
        .rdata (ram_q)
    );

    // Pointers, fill count and all status flags are registered from the
    // post-update count. Overall occupancy never exceeds DEPTH, so a write
    // can never land on a RAM slot that is still unread.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            ram_words    <= '0;
            full         <= 1'b0;
            almost_full  <= 1'b0;
            empty        <= 1'b1;
            almost_empty <= 1'b1;
            overflow     <= 1'b0;
            underflow    <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (ram_re) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            count        <= count_next;
            ram_words    <= ram_words_next;
            full         <= (count_next == (AW+1)'(DEPTH));
            almost_full  <= (count_next >= (AW+1)'(AF_LVL));
            almost_empty <= (count_next <= (AW+1)'(AE_LVL));
            empty        <= FWFT ? (state_next != ST_VALID) : (count_next == '0);
            overflow     <= wr_en && full;
            underflow    <= rd_en && empty;
        end
    end

    // Prefetch FSM state register.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Prefetch FSM next state. VALID persists while any word remains to
    // replace a popped one: the skid register or a RAM read in flight.
    always_comb begin
        state_next = state;
        if (FWFT) begin
            unique case (state)
                ST_IDLE:  state_next = fetch ? ST_FETCH : ST_IDLE;
                ST_FETCH: state_next = ST_VALID;
                ST_VALID: begin
                    if (!rd_acc || skid_vld || q_vld) begin
                        state_next = ST_VALID;
                    end else begin
                        state_next = fetch ? ST_FETCH : ST_IDLE;
                    end
                end
                default:  state_next = ST_IDLE;
            endcase
        end else begin
            state_next = ST_IDLE;
        end
    end

    // Prefetch FSM outputs. A RAM read is issued only when at most one word
    // will still be held after this edge. The returning word then always
    // finds room in either the output register or the skid register, which
    // keeps sustained reads at one word per cycle.
    always_comb begin
        out_vld    = (state == ST_VALID);
        held_after = 2'(out_vld) + 2'(skid_vld) + 2'(q_vld) - 2'(rd_acc);
        fetch      = 1'b0;
        if (FWFT) begin
            fetch = (ram_words != '0) && (held_after <= 2'd1);
        end
    end

    // Output datapath.
    // FWFT: move words RAM -> skid -> dout in order; dout holds when not popped.
    // Standard: dout loads RAM data one cycle after the accepted read.
    always_ff @(posedge clk or negedge rst_int_n) begin
        if (!rst_int_n) begin
            dout     <= '0;
            skid_q   <= '0;
            skid_vld <= 1'b0;
            q_vld    <= 1'b0;
            rd_pend  <= 1'b0;
        end else if (FWFT) begin
            q_vld <= fetch;
            if (out_vld && !rd_acc) begin
                if (q_vld) begin
                    skid_q   <= ram_q;
                    skid_vld <= 1'b1;
                end
            end else if (skid_vld) begin
                dout     <= skid_q;
                skid_vld <= q_vld;
                if (q_vld) begin
                    skid_q <= ram_q;
                end
            end else if (q_vld) begin
                dout <= ram_q;
            end
        end else begin
            rd_pend <= rd_acc;
            if (rd_pend) begin
                dout <= ram_q;
            end
        end
    end

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param
// Bench for two DEPTH=16 FIFOs (AF_LVL=12, AE_LVL=3): one in FWFT mode, one in
// standard-read mode. A scoreboard queue tracks the data in the FWFT FIFO, and
// a table of single-cycle vectors covers the threshold and boundary cases.
module tb_sfifo_param;

    localparam int DW = 32;

    logic          clk;
    logic          rst_n;

    logic [DW-1:0] din_f, dout_f;
    logic          wr_f, rd_f, full_f, afull_f, empty_f, aempty_f, ovf_f, unf_f;
    logic [4:0]    count_f;

    logic [DW-1:0] din_s, dout_s;
    logic          wr_s, rd_s, full_s, afull_s, empty_s, aempty_s, ovf_s, unf_s;
    logic [4:0]    count_s;

    int            checks;
    int            passed;
    int            mcount;
    logic [DW-1:0] sb[$];
    logic [DW-1:0] sb_s[$];
    logic [DW-1:0] next_data;

    typedef struct {
        string name;
        int    pre;
        bit    wr;
        bit    rd;
        int    cnt;
        bit    full;
        bit    empty;
        bit    af;
        bit    ae;
        bit    ovf;
        bit    unf;
    } vec_t;

    vec_t vecs[7];

    sfifo_param #(.DATA_W(DW), .DEPTH(16), .FWFT(1'b1), .AF_LVL(12), .AE_LVL(3)) dut_f (
        .clk(clk), .rst_n(rst_n), .din(din_f), .wr_en(wr_f), .full(full_f),
        .almost_full(afull_f), .dout(dout_f), .rd_en(rd_f), .empty(empty_f),
        .almost_empty(aempty_f), .count(count_f), .overflow(ovf_f), .underflow(unf_f)
    );

    sfifo_param #(.DATA_W(DW), .DEPTH(16), .FWFT(1'b0), .AF_LVL(12), .AE_LVL(3)) dut_s (
        .clk(clk), .rst_n(rst_n), .din(din_s), .wr_en(wr_s), .full(full_s),
        .almost_full(afull_s), .dout(dout_s), .rd_en(rd_s), .empty(empty_s),
        .almost_empty(aempty_s), .count(count_s), .overflow(ovf_s), .underflow(unf_s)
    );

    // Free-running 100 MHz-style clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard bound on run time.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: run exceeded time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual === expected) begin
            passed++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One cycle on the FWFT FIFO. The model decides acceptance: a write is
    // accepted below 16 words, and a read is accepted when words are held
    // (the bench reads only from a settled FIFO). The task compares the
    // popped word and the post-edge count and flags.
    task automatic applyStimulus(input bit wr, input bit rd, input logic [DW-1:0] d);
        bit            wr_ok;
        bit            rd_ok;
        logic [DW-1:0] exp_d;
        wr_ok = wr && (mcount < 16);
        rd_ok = rd && (mcount > 0);
        wr_f  = wr;
        rd_f  = rd;
        din_f = d;
        if (rd_ok) begin
            exp_d = sb.pop_front();
            checkOutput("fwft_dout", dout_f, exp_d);
            checkOutput("fwft_not_empty", empty_f, 1'b0);
        end
        step();
        wr_f = 1'b0;
        rd_f = 1'b0;
        if (wr_ok) sb.push_back(d);
        mcount = mcount + int'(wr_ok) - int'(rd_ok);
        checkOutput("count", count_f, mcount);
        checkOutput("full", full_f, mcount == 16);
        checkOutput("almost_full", afull_f, mcount >= 12);
        checkOutput("almost_empty", aempty_f, mcount <= 3);
        checkOutput("overflow", ovf_f, wr && !wr_ok);
        checkOutput("underflow", unf_f, rd && !rd_ok);
    endtask

    task automatic fillTo(input int n);
        while (mcount < n) begin
            applyStimulus(1'b1, 1'b0, next_data);
            next_data++;
        end
        while (mcount > n) begin
            applyStimulus(1'b0, 1'b1, '0);
        end
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
    endtask

    initial begin
        bit prev_rd;

        checks    = 0;
        passed    = 0;
        mcount    = 0;
        next_data = 32'h0000_0100;
        rst_n     = 1'b0;
        wr_f = 1'b0; rd_f = 1'b0; din_f = '0;
        wr_s = 1'b0; rd_s = 1'b0; din_s = '0;

        vecs[0] = '{"rw_empty",   0, 1'b1, 1'b1,  1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[1] = '{"ae_drop_4",  3, 1'b1, 1'b0,  4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2] = '{"ae_at_3",    4, 1'b0, 1'b1,  3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"rw_mid",     8, 1'b1, 1'b1,  8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{"af_at_12",  11, 1'b1, 1'b0, 12, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5] = '{"af_drop_11",12, 1'b0, 1'b1, 11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6] = '{"rw_full",   16, 1'b1, 1'b1, 15, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

        repeat (3) step();
        rst_n = 1'b1;
        repeat (4) step();

        $display("[TB] reset state");
        checkOutput("rst_count", count_f, 0);
        checkOutput("rst_empty", empty_f, 1);
        checkOutput("rst_almost_empty", aempty_f, 1);
        checkOutput("rst_full", full_f, 0);
        checkOutput("rst_almost_full", afull_f, 0);
        checkOutput("rst_dout", dout_f, 0);
        checkOutput("rst_overflow", ovf_f, 0);
        checkOutput("rst_underflow", unf_f, 0);
        checkOutput("rst_s_empty", empty_s, 1);
        checkOutput("rst_s_count", count_s, 0);

        $display("[TB] standard read latency");
        wr_s = 1'b1; din_s = 32'h0000_1234;
        step();
        wr_s = 1'b0;
        checkOutput("std_empty_after_wr", empty_s, 0);
        checkOutput("std_count_after_wr", count_s, 1);
        rd_s = 1'b1;
        step();
        rd_s = 1'b0;
        checkOutput("std_count_after_rd", count_s, 0);
        checkOutput("std_empty_after_rd", empty_s, 1);
        checkOutput("std_dout_edge_k", dout_s, 0);
        step();
        checkOutput("std_dout_edge_k1", dout_s, 32'h0000_1234);
        rd_s = 1'b1;
        step();
        rd_s = 1'b0;
        checkOutput("std_underflow", unf_s, 1);
        checkOutput("std_dout_hold", dout_s, 32'h0000_1234);
        step();
        checkOutput("std_underflow_clear", unf_s, 0);
        for (int i = 0; i < 3; i++) begin
            wr_s  = 1'b1;
            din_s = 32'hC0DE_0000 + i;
            sb_s.push_back(din_s);
            step();
        end
        wr_s    = 1'b0;
        prev_rd = 1'b0;
        for (int i = 0; i < 5; i++) begin
            rd_s = (i < 3);
            step();
            if (prev_rd) checkOutput("std_stream_dout", dout_s, sb_s.pop_front());
            prev_rd = (i < 3);
        end
        rd_s = 1'b0;

        $display("[TB] FWFT first-word latency");
        applyStimulus(1'b1, 1'b0, 32'hA5A5_0001);
        checkOutput("fwft_empty_edge_k", empty_f, 1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("fwft_empty_edge_k1", empty_f, 1);
        applyStimulus(1'b0, 1'b0, '0);
        checkOutput("fwft_empty_edge_k2", empty_f, 0);
        checkOutput("fwft_dout_edge_k2", dout_f, 32'hA5A5_0001);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("fwft_empty_after_pop", empty_f, 1);

        $display("[TB] fill and drain");
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 1'b0, DW'(i));
        checkOutput("fill_full", full_f, 1);
        applyStimulus(1'b1, 1'b0, 32'hDEAD_0017);
        checkOutput("fill_overflow_pulse", ovf_f, 1);
        applyStimulus(1'b0, 1'b0, '0);
        for (int i = 0; i < 16; i++) applyStimulus(1'b0, 1'b1, '0);
        checkOutput("drain_empty", empty_f, 1);
        applyStimulus(1'b0, 1'b1, '0);
        checkOutput("drain_underflow_pulse", unf_f, 1);
        applyStimulus(1'b0, 1'b0, '0);

        $display("[TB] vector table");
        for (int v = 0; v < 7; v++) begin
            fillTo(vecs[v].pre);
            applyStimulus(vecs[v].wr, vecs[v].rd, next_data);
            next_data++;
            checkOutput({vecs[v].name, "_count"}, count_f, vecs[v].cnt);
            checkOutput({vecs[v].name, "_full"}, full_f, vecs[v].full);
            checkOutput({vecs[v].name, "_empty"}, empty_f, vecs[v].empty);
            checkOutput({vecs[v].name, "_af"}, afull_f, vecs[v].af);
            checkOutput({vecs[v].name, "_ae"}, aempty_f, vecs[v].ae);
            checkOutput({vecs[v].name, "_ovf"}, ovf_f, vecs[v].ovf);
            checkOutput({vecs[v].name, "_unf"}, unf_f, vecs[v].unf);
        end

        $display("[TB] FWFT sustained throughput");
        fillTo(10);
        for (int i = 0; i < 100; i++) begin
            applyStimulus(1'b1, 1'b1, next_data);
            next_data++;
        end

        $display("[TB] reset mid-stream");
        checkOutput("pre_reset_count", count_f, 10);
        rst_n = 1'b0;
        #2;
        checkOutput("in_reset_count", count_f, 0);
        checkOutput("in_reset_empty", empty_f, 1);
        checkOutput("in_reset_dout", dout_f, 0);
        repeat (2) step();
        rst_n = 1'b1;
        repeat (4) step();
        mcount = 0;
        sb.delete();
        checkOutput("post_reset_count", count_f, 0);
        checkOutput("post_reset_empty", empty_f, 1);
        checkOutput("post_reset_dout", dout_f, 0);
        checkOutput("post_reset_overflow", ovf_f, 0);
        checkOutput("post_reset_underflow", unf_f, 0);
        applyStimulus(1'b1, 1'b0, 32'hBEEF_0002);
        repeat (3) applyStimulus(1'b0, 1'b0, '0);
        applyStimulus(1'b0, 1'b1, '0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
